calc2_port_responder: RTL and testbench

CALC2_PORT_RESPONDER -- requirements
Module: calc2_port_responder

---
 rtl/calc2_port_responder.sv | 162 ++++++++++++++++
 tb/tb_calc2_port_responder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc2_port_responder.sv
// Two-cycle command/operand responder: add, sub, shift-left/right with per-tag busy tracking.
// Response is registered LATENCY+1 cycles after the command cycle; there is no backpressure, one request per 2 cycles.
module calc2_port_responder #(
  parameter int LATENCY = 3
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req_cmd_in,
  input  logic [31:0] req_data_in,
  input  logic [1:0]  req_tag_in,
  output logic [1:0]  out_resp,
  output logic [31:0] out_data,
  output logic [1:0]  out_tag
);

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;

  typedef enum logic {
    ST_IDLE,
    ST_OP2
  } state_t;

  // own marks entries that hold a busy bit and must release it when emitted
  typedef struct packed {
    logic        own;
    logic [1:0]  resp;
    logic [31:0] dat;
    logic [1:0]  tag;
  } entry_t;

  state_t      state_q, state_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [31:0] op1_q, op1_d;
  logic [1:0]  tag_q, tag_d;
  logic        dup_q, dup_d;
  logic [3:0]  busy_q, busy_d;
  logic [3:0]  set_mask;
  logic [3:0]  clr_mask;

  entry_t      pipe_q [LATENCY];
  entry_t      new_ent;
  entry_t      tail;

  logic [1:0]  out_resp_q;
  logic [31:0] out_data_q;
  logic [1:0]  out_tag_q;

  logic [32:0] add_sum;
  logic [4:0]  shamt;

  function automatic logic cmd_is_valid(input logic [3:0] c);
    return (c == CMD_ADD) || (c == CMD_SUB) || (c == CMD_SHL) || (c == CMD_SHR);
  endfunction

  assign tail    = pipe_q[LATENCY-1];
  assign add_sum = {1'b0, op1_q} + {1'b0, req_data_in};
  assign shamt   = req_data_in[4:0];

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    op1_d    = op1_q;
    tag_d    = tag_q;
    dup_d    = dup_q;
    set_mask = '0;
    clr_mask = '0;
    new_ent  = '0;

    if (tail.own) begin
      clr_mask[tail.tag] = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_cmd_in != 4'd0) begin
          cmd_d = req_cmd_in;
          op1_d = req_data_in;
          tag_d = req_tag_in;
          // a bit releasing on this very edge no longer blocks its tag
          dup_d = busy_q[req_tag_in] & ~clr_mask[req_tag_in];
          if (cmd_is_valid(req_cmd_in) && !dup_d) begin
            set_mask[req_tag_in] = 1'b1;
          end
          state_d = ST_OP2;
        end
      end

      ST_OP2: begin
        new_ent.tag  = tag_q;
        new_ent.resp = RESP_OK;
        case (cmd_q)
          CMD_ADD: begin
            if (add_sum[32]) new_ent.resp = RESP_ERR;
            else             new_ent.dat  = add_sum[31:0];
          end
          CMD_SUB: begin
            if (req_data_in > op1_q) new_ent.resp = RESP_ERR;
            else                     new_ent.dat  = op1_q - req_data_in;
          end
          CMD_SHL: new_ent.dat  = op1_q << shamt;
          CMD_SHR: new_ent.dat  = op1_q >> shamt;
          default: new_ent.resp = RESP_ERR;
        endcase
        if (dup_q) begin
          new_ent.resp = RESP_ERR;
        end
        if (new_ent.resp == RESP_ERR) begin
          new_ent.dat = '0;
        end
        new_ent.own = cmd_is_valid(cmd_q) && !dup_q;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      op1_q      <= '0;
      tag_q      <= '0;
      dup_q      <= 1'b0;
      busy_q     <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
      out_resp_q <= '0;
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      op1_q      <= op1_d;
      tag_q      <= tag_d;
      dup_q      <= dup_d;
      busy_q     <= busy_d;
      pipe_q[0]  <= new_ent;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      // empty slots are all-zero, so a plain copy yields idle outputs
      out_resp_q <= tail.resp;
      out_data_q <= tail.dat;
      out_tag_q  <= tail.tag;
    end
  end

  assign out_resp = out_resp_q;
  assign out_data = out_data_q;
  assign out_tag  = out_tag_q;

endmodule

// File: tb/tb_calc2_port_responder.sv
// Directed bench for calc2_port_responder; outputs are logged per cycle and checked against hand-computed values.
module tb_calc2_port_responder;

  localparam int LAT = 3;
  localparam int R   = LAT + 1;

  logic        c_clk;
  logic        reset;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  req_tag_in;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;

  int tests;
  int fails;
  int cyc;
  logic [35:0] hist [4096];

  calc2_port_responder #(.LATENCY(LAT)) dut (
    .c_clk      (c_clk),
    .reset      (reset),
    .req_cmd_in (req_cmd_in),
    .req_data_in(req_data_in),
    .req_tag_in (req_tag_in),
    .out_resp   (out_resp),
    .out_data   (out_data),
    .out_tag    (out_tag)
  );

  initial begin
    c_clk = 1'b0;
    forever #5 c_clk = ~c_clk;
  end

  // cyc == k at the negedge following the k-th rising edge
  initial cyc = 0;
  always @(posedge c_clk) cyc = cyc + 1;
  always @(negedge c_clk) if (cyc < 4096) hist[cyc] = {out_resp, out_data, out_tag};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d, required finish before 10000", cyc);
    $fatal(1);
  end

  task automatic wait_cyc(input int k);
    repeat (k) @(negedge c_clk);
  endtask

  // Returns n = edge index at which the command is sampled; operand 2 goes in at n+1.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] tag, output int n);
    req_cmd_in  = cmd;
    req_data_in = a;
    req_tag_in  = tag;
    @(negedge c_clk);
    n           = cyc;
    req_data_in = b;
    req_cmd_in  = 4'h1;
    req_tag_in  = ~tag;
    @(negedge c_clk);
    req_cmd_in  = 4'h0;
    req_data_in = 32'h0;
    req_tag_in  = 2'h0;
  endtask

  task automatic test_reset();
    int n;
    logic bad;
    reset       = 1'b1;
    req_cmd_in  = 4'h1;
    req_data_in = 32'h5;
    req_tag_in  = 2'h2;
    wait_cyc(3);
    tests++;
    if ({out_resp, out_data, out_tag} !== 36'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want %h", {out_resp, out_data, out_tag}, 36'h0);
    end
    req_cmd_in  = 4'h0;
    reset       = 1'b0;
    n = cyc;
    wait_cyc(6);
    bad = 1'b0;
    for (int k = n + 1; k <= n + 6; k++) if (hist[k] !== 36'h0) bad = 1'b1;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL reset_inputs_ignored: got nonzero output after reset, want all zero");
    end
    // first command sampled at the first edge with reset low
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    issue(4'h1, 32'h3, 32'h4, 2'h2, n);
    wait_cyc(R + 1);
    tests++;
    if (hist[n + R] !== {2'd1, 32'h7, 2'd2}) begin
      fails++;
      $display("FAIL first_after_reset: got %h want %h", hist[n + R], {2'd1, 32'h7, 2'd2});
    end
  endtask

  task automatic test_add_basic();
    int n;
    issue(4'h1, 32'h30, 32'h20, 2'h1, n);
    wait_cyc(R + 1);
    tests++;
    if (hist[n + R - 1] !== 36'h0) begin
      fails++;
      $display("FAIL add_early: got %h want %h", hist[n + R - 1], 36'h0);
    end
    tests++;
    if (hist[n + R] !== {2'd1, 32'h50, 2'd1}) begin
      fails++;
      $display("FAIL add_basic: got %h want %h", hist[n + R], {2'd1, 32'h50, 2'd1});
    end
    tests++;
    if (hist[n + R + 1] !== 36'h0) begin
      fails++;
      $display("FAIL add_one_cycle: got %h want %h", hist[n + R + 1], 36'h0);
    end
  endtask

  task automatic test_arith_errors();
    int n;
    issue(4'h1, 32'hFFFF_FFFF, 32'h1, 2'h2, n);
    wait_cyc(R + 1);
    tests++;
    if (hist[n + R] !== {2'd2, 32'h0, 2'd2}) begin
      fails++;
      $display("FAIL add_carry: got %h want %h", hist[n + R], {2'd2, 32'h0, 2'd2});
    end
    issue(4'h2, 32'h10, 32'h20, 2'h3, n);
    wait_cyc(R + 1);
    tests++;
    if (hist[n + R] !== {2'd2, 32'h0, 2'd3}) begin
      fails++;
      $display("FAIL sub_underflow: got %h want %h", hist[n + R], {2'd2, 32'h0, 2'd3});
    end
    issue(4'h2, 32'h20, 32'h10, 2'h0, n);
    wait_cyc(R + 1);
    tests++;
    if (hist[n + R] !== {2'd1, 32'h10, 2'd0}) begin
      fails++;
      $display("FAIL sub_ok: got %h want %h", hist[n + R], {2'd1, 32'h10, 2'd0});
    end
    issue(4'h2, 32'h1234_5678, 32'h1234_5678, 2'h1, n);
    wait_cyc(R + 1);
    tests++;
    if (hist[n + R] !== {2'd1, 32'h0, 2'd1}) begin
      fails++;
      $display("FAIL sub_equal: got %h want %h", hist[n + R], {2'd1, 32'h0, 2'd1});
    end
  endtask

  task automatic test_shift();
    int n;
    issue(4'h5, 32'h1, 32'h24, 2'h1, n);
    wait_cyc(R + 1);
    tests++;
    if (hist[n + R] !== {2'd1, 32'h10, 2'd1}) begin
      fails++;
      $display("FAIL shl: got %h want %h", hist[n + R], {2'd1, 32'h10, 2'd1});
    end
    issue(4'h6, 32'h8000_0000, 32'h1F, 2'h2, n);
    wait_cyc(R + 1);
    tests++;
    if (hist[n + R] !== {2'd1, 32'h1, 2'd2}) begin
      fails++;
      $display("FAIL shr: got %h want %h", hist[n + R], {2'd1, 32'h1, 2'd2});
    end
  endtask

  task automatic test_back_to_back();
    int n0, n1;
    issue(4'h1, 32'h1, 32'h1, 2'h0, n0);
    issue(4'h1, 32'h2, 32'h2, 2'h0, n1);
    wait_cyc(R + 2);
    tests++;
    if (hist[n0 + R] !== {2'd1, 32'h2, 2'd0}) begin
      fails++;
      $display("FAIL b2b_first: got %h want %h", hist[n0 + R], {2'd1, 32'h2, 2'd0});
    end
    tests++;
    if (hist[n0 + R + 1] !== 36'h0) begin
      fails++;
      $display("FAIL b2b_gap: got %h want %h", hist[n0 + R + 1], 36'h0);
    end
    tests++;
    if (hist[n1 + R] !== {2'd2, 32'h0, 2'd0} || n1 != n0 + 2) begin
      fails++;
      $display("FAIL b2b_dup: got %h at +%0d want %h at +2", hist[n1 + R], n1 - n0, {2'd2, 32'h0, 2'd0});
    end
    // different tags, both succeed in order
    issue(4'h1, 32'h3, 32'h4, 2'h1, n0);
    issue(4'h2, 32'h9, 32'h4, 2'h2, n1);
    wait_cyc(R + 2);
    tests++;
    if (hist[n0 + R] !== {2'd1, 32'h7, 2'd1} || hist[n1 + R] !== {2'd1, 32'h5, 2'd2}) begin
      fails++;
      $display("FAIL b2b_tags: got %h %h want %h %h", hist[n0 + R], hist[n1 + R],
               {2'd1, 32'h7, 2'd1}, {2'd1, 32'h5, 2'd2});
    end
  endtask

  task automatic test_dup_chain();
    int na, nb, nc, nd;
    // C samples on A's release edge; D collides with C while dup B drains
    issue(4'h1, 32'h10, 32'h1, 2'h1, na);
    issue(4'h1, 32'h20, 32'h2, 2'h1, nb);
    issue(4'h1, 32'h30, 32'h3, 2'h1, nc);
    issue(4'h1, 32'h40, 32'h4, 2'h1, nd);
    wait_cyc(R + 2);
    tests++;
    if (hist[na + R] !== {2'd1, 32'h11, 2'd1}) begin
      fails++;
      $display("FAIL dup_a: got %h want %h", hist[na + R], {2'd1, 32'h11, 2'd1});
    end
    tests++;
    if (hist[nb + R] !== {2'd2, 32'h0, 2'd1}) begin
      fails++;
      $display("FAIL dup_b: got %h want %h", hist[nb + R], {2'd2, 32'h0, 2'd1});
    end
    tests++;
    if (hist[nc + R] !== {2'd1, 32'h33, 2'd1}) begin
      fails++;
      $display("FAIL same_edge_release: got %h want %h", hist[nc + R], {2'd1, 32'h33, 2'd1});
    end
    tests++;
    if (hist[nd + R] !== {2'd2, 32'h0, 2'd1}) begin
      fails++;
      $display("FAIL dup_keeps_busy: got %h want %h", hist[nd + R], {2'd2, 32'h0, 2'd1});
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic bad;
    issue(4'h1, 32'h5, 32'h5, 2'h3, n);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    wait_cyc(11);
    bad = 1'b0;
    for (int k = n + 2; k <= n + 11; k++) if (hist[k] !== 36'h0) bad = 1'b1;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL reset_in_flight: got nonzero output within 10 cycles, want all zero");
    end
    // reset while in OP2
    req_cmd_in  = 4'h1;
    req_data_in = 32'h9;
    req_tag_in  = 2'h0;
    @(negedge c_clk);
    n           = cyc;
    reset       = 1'b1;
    req_cmd_in  = 4'h0;
    req_data_in = 32'h9;
    @(negedge c_clk);
    reset       = 1'b0;
    req_data_in = 32'h0;
    wait_cyc(10);
    bad = 1'b0;
    for (int k = n + 1; k <= n + 10; k++) if (hist[k] !== 36'h0) bad = 1'b1;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL reset_in_op2: got nonzero output, want all zero");
    end
    issue(4'h1, 32'h6, 32'h1, 2'h3, n);
    wait_cyc(R + 1);
    tests++;
    if (hist[n + R] !== {2'd1, 32'h7, 2'd3}) begin
      fails++;
      $display("FAIL after_reset_tag3: got %h want %h", hist[n + R], {2'd1, 32'h7, 2'd3});
    end
  endtask

  task automatic test_invalid();
    int n0, n1;
    issue(4'h4, 32'h7, 32'h8, 2'h1, n0);
    issue(4'h1, 32'h7, 32'h8, 2'h1, n1);
    wait_cyc(R + 2);
    tests++;
    if (hist[n0 + R] !== {2'd2, 32'h0, 2'd1}) begin
      fails++;
      $display("FAIL invalid_cmd4: got %h want %h", hist[n0 + R], {2'd2, 32'h0, 2'd1});
    end
    tests++;
    if (hist[n1 + R] !== {2'd1, 32'hF, 2'd1}) begin
      fails++;
      $display("FAIL invalid_no_busy: got %h want %h", hist[n1 + R], {2'd1, 32'hF, 2'd1});
    end
    issue(4'hF, 32'h1, 32'h1, 2'h2, n0);
    wait_cyc(R + 1);
    tests++;
    if (hist[n0 + R] !== {2'd2, 32'h0, 2'd2}) begin
      fails++;
      $display("FAIL invalid_cmd15: got %h want %h", hist[n0 + R], {2'd2, 32'h0, 2'd2});
    end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    reset       = 1'b1;
    req_cmd_in  = 4'h0;
    req_data_in = 32'h0;
    req_tag_in  = 2'h0;
    test_reset();
    test_add_basic();
    test_arith_errors();
    test_shift();
    test_back_to_back();
    test_dup_chain();
    test_reset_mid();
    test_invalid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
